// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
// Shared constants and types for the pipeline hazard controller.
//   - REG_ADDR_W : register-index width, shared with the register file
//   - hz_state_e : controller FSM state encoding
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } hz_state_e;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt
// Saturating event counter. With EN=0 it builds no flops and drives zero.
// Ports:
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   i_inc    : count this cycle
//   o_count  : current count, sticks at all-ones
module hazard_perf_cnt #(
    parameter int W  = 32,
    parameter bit EN = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    generate
        if (EN) begin : g_cnt
            localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
            logic [W-1:0] r_count;

            // Saturating count register.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_count <= {W{1'b0}};
                end else if (i_inc && (r_count != {W{1'b1}})) begin
                    r_count <= r_count + ONE;
                end else begin
                    r_count <= r_count;
                end
            end

            assign o_count = r_count;
        end else begin : g_off
            logic w_unused;
            assign w_unused = &{1'b0, i_clk, i_rst_n, i_inc};
            assign o_count  = {W{1'b0}};
        end
    endgenerate

endmodule : hazard_perf_cnt

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage in-order pipeline. Produces
// the ready_go/clear controls of IF/ID, ID/EX and EX/MEM and the PC redirect
// select. Priority: memory wait > redirect > load-use.
// Optional feature macro: HAZARD_PERF_EN (stall/flush performance counters;
// when undefined both counter ports are constant 0 and no counter flops exist).
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   id_valid/id_rs1/id_rs2/id_use_* : ID-stage source operand info
//   ex_valid/ex_L_type/ex_Rd        : EX-stage instruction info (load detect)
//   ex_redirect                     : taken branch/JAL/JALR resolved in EX
//   mem_req/dmem_ready              : MEM access request and acknowledge
//   *_ready_go                      : stage hand-over enables
//   if_id_clear/id_ex_clear         : pipeline register invalidates
//   pc_redirect                     : PC mux selects EX target
//   stall_cycles/flush_count        : performance counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = pipe_hazard_ctrl_pkg::REG_ADDR_W,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_L_type,
    input  logic [REG_ADDR_W-1:0] ex_Rd,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  dmem_ready,
    output logic                  if_id_ready_go,
    output logic                  id_ex_ready_go,
    output logic                  ex_mem_ready_go,
    output logic                  if_id_clear,
    output logic                  id_ex_clear,
    output logic                  pc_redirect,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

`ifdef HAZARD_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    hz_state_e  r_state;
    hz_state_e  w_state_nxt;
    logic [1:0] r_flush_cnt;
    logic [1:0] w_flush_cnt_nxt;
    logic       w_mem_stall;
    logic       w_load_use;
    logic       w_any_stall;

    assign w_mem_stall = mem_req & ~dmem_ready;

    // x0 is never a real dependency, so a load targeting it cannot stall.
    assign w_load_use = ex_valid & ex_L_type & (ex_Rd != {REG_ADDR_W{1'b0}}) & id_valid &
                        ((id_use_rs1 & (id_rs1 == ex_Rd)) | (id_use_rs2 & (id_rs2 == ex_Rd)));

    // State and flush down-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Next-state and stage control decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        if_id_ready_go  = 1'b1;
        id_ex_ready_go  = 1'b1;
        ex_mem_ready_go = 1'b1;
        if_id_clear     = 1'b0;
        id_ex_clear     = 1'b0;
        pc_redirect     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    if_id_ready_go  = 1'b0;
                    id_ex_ready_go  = 1'b0;
                    ex_mem_ready_go = 1'b0;
                    w_state_nxt     = ST_MEM_WAIT;
                end else if (ex_redirect) begin
                    // The ID instruction is flushed, so any load-use match is moot.
                    pc_redirect     = 1'b1;
                    if_id_clear     = 1'b1;
                    id_ex_clear     = 1'b1;
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end else if (w_load_use) begin
                    if_id_ready_go  = 1'b0;
                    id_ex_ready_go  = 1'b0;
                end else begin
                    w_state_nxt     = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                // A non-zero counter means the wait interrupted a flush.
                if (dmem_ready) begin
                    w_state_nxt = (r_flush_cnt != 2'd0) ? ST_FLUSH : ST_RUN;
                end else begin
                    if_id_ready_go  = 1'b0;
                    id_ex_ready_go  = 1'b0;
                    ex_mem_ready_go = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (w_mem_stall) begin
                    if_id_ready_go  = 1'b0;
                    id_ex_ready_go  = 1'b0;
                    ex_mem_ready_go = 1'b0;
                    w_state_nxt     = ST_MEM_WAIT;
                end else if (ex_redirect) begin
                    pc_redirect     = 1'b1;
                    if_id_clear     = 1'b1;
                    id_ex_clear     = 1'b1;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end else begin
                    if_id_clear = 1'b1;
                    if (r_flush_cnt <= 2'd1) begin
                        w_flush_cnt_nxt = 2'd0;
                        w_state_nxt     = ST_RUN;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt     = ST_RUN;
                w_flush_cnt_nxt = 2'd0;
            end
        endcase
    end

    assign w_any_stall = ~(if_id_ready_go & id_ex_ready_go & ex_mem_ready_go);

    hazard_perf_cnt #(.W(CNT_W), .EN(PERF_EN)) u_stall_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_inc   (w_any_stall),
        .o_count (stall_cycles)
    );

    hazard_perf_cnt #(.W(CNT_W), .EN(PERF_EN)) u_flush_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_inc   (pc_redirect),
        .o_count (flush_count)
    );

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl (FLUSH_CYCLES=2) with a rule-level
// reference model compared every cycle, plus literal expectations per scenario.
// Honours HAZARD_PERF_EN for the counter expectations.
module tb_pipe_hazard_ctrl;

    localparam int FC    = 2;
    localparam int CNT_W = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs1, id_use_rs2;
    logic [4:0] id_rs1, id_rs2, ex_Rd;
    logic       ex_valid, ex_L_type, ex_redirect, mem_req, dmem_ready;
    logic       if_id_ready_go, id_ex_ready_go, ex_mem_ready_go;
    logic       if_id_clear, id_ex_clear, pc_redirect;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_valid        (ex_valid),
        .ex_L_type       (ex_L_type),
        .ex_Rd           (ex_Rd),
        .ex_redirect     (ex_redirect),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .if_id_ready_go  (if_id_ready_go),
        .id_ex_ready_go  (id_ex_ready_go),
        .ex_mem_ready_go (ex_mem_ready_go),
        .if_id_clear     (if_id_clear),
        .id_ex_clear     (id_ex_clear),
        .pc_redirect     (pc_redirect),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_waiting;       // data memory has not yet acknowledged a blocked access
    int m_flush_left;    // remaining IF/ID clear cycles after a redirect
    int m_stalls, m_flushes;
    bit e_hit, e_block, e_taken;
    bit e_rg_front, e_rg_ex, e_ifc, e_idc, e_pc;

    always_comb begin
        e_hit = ex_valid && ex_L_type && (ex_Rd != 5'd0) && id_valid &&
                ((id_use_rs1 && id_rs1 == ex_Rd) || (id_use_rs2 && id_rs2 == ex_Rd));
        e_block    = m_waiting ? !dmem_ready : (mem_req && !dmem_ready);
        e_taken    = !m_waiting && !e_block && ex_redirect;
        e_rg_ex    = !e_block;
        e_rg_front = !e_block && !(e_hit && !m_waiting && m_flush_left == 0 && !e_taken);
        e_ifc      = e_taken || (!m_waiting && !e_block && m_flush_left > 0);
        e_idc      = e_taken;
        e_pc       = e_taken;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_waiting    <= 1'b0;
            m_flush_left <= 0;
            m_stalls     <= 0;
            m_flushes    <= 0;
        end else begin
            if (!e_rg_front || !e_rg_ex) m_stalls <= m_stalls + 1;
            if (e_pc) m_flushes <= m_flushes + 1;
            if (m_waiting) begin
                if (dmem_ready) m_waiting <= 1'b0;
            end else if (e_block) begin
                m_waiting <= 1'b1;
            end else if (e_taken) begin
                m_flush_left <= FC;
            end else if (m_flush_left > 0) begin
                m_flush_left <= m_flush_left - 1;
            end
        end
    end

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef HAZARD_PERF_EN
        return v;
`else
        return (v >= 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmp_if_id_ready_go",  if_id_ready_go,  e_rg_front);
            chk("cmp_id_ex_ready_go",  id_ex_ready_go,  e_rg_front);
            chk("cmp_ex_mem_ready_go", ex_mem_ready_go, e_rg_ex);
            chk("cmp_if_id_clear",     if_id_clear,     e_ifc);
            chk("cmp_id_ex_clear",     id_ex_clear,     e_idc);
            chk("cmp_pc_redirect",     pc_redirect,     e_pc);
            chk("cmp_stall_cycles",    stall_cycles,    exp_cnt(m_stalls));
            chk("cmp_flush_count",     flush_count,     exp_cnt(m_flushes));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_valid = 1'b0; ex_L_type = 1'b0; ex_Rd = 5'd0; ex_redirect = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic rgf, input logic rge,
                           input logic ifc, input logic idc, input logic pc);
        chk({tag, "_if_id_ready_go"},  if_id_ready_go,  rgf);
        chk({tag, "_id_ex_ready_go"},  id_ex_ready_go,  rgf);
        chk({tag, "_ex_mem_ready_go"}, ex_mem_ready_go, rge);
        chk({tag, "_if_id_clear"},     if_id_clear,     ifc);
        chk({tag, "_id_ex_clear"},     id_ex_clear,     idc);
        chk({tag, "_pc_redirect"},     pc_redirect,     pc);
    endtask

    task automatic drive_lu(input logic ev, input logic lt, input logic [4:0] rd, input logic iv,
                            input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
        ex_valid = ev; ex_L_type = lt; ex_Rd = rd; id_valid = iv;
        id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    endtask

    typedef struct {
        logic ev, lt; logic [4:0] rd; logic iv;
        logic [4:0] r1; logic u1; logic [4:0] r2; logic u2;
        logic stall;
    } lu_vec_t;
    lu_vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  1'b0, 1'b0}; // load to x0
        vecs[1] = '{1'b1, 1'b1, 5'd7,  1'b1, 5'd3,  1'b1, 5'd7,  1'b1, 1'b1}; // rs2 match
        vecs[2] = '{1'b1, 1'b1, 5'd7,  1'b1, 5'd7,  1'b0, 5'd7,  1'b0, 1'b0}; // match, not read
        vecs[3] = '{1'b1, 1'b1, 5'd9,  1'b0, 5'd9,  1'b1, 5'd0,  1'b0, 1'b0}; // ID invalid
        vecs[4] = '{1'b1, 1'b0, 5'd9,  1'b1, 5'd9,  1'b1, 5'd0,  1'b0, 1'b0}; // not a load
        vecs[5] = '{1'b1, 1'b1, 5'd31, 1'b1, 5'd30, 1'b1, 5'd31, 1'b1, 1'b1}; // rs2 of both

        idle();
        rst_n  = 1'b0;
        chk_on = 1'b1;
        #3;
        chk_all("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_stall_cycles", stall_cycles, 32'd0);
        chk("reset_flush_count",  flush_count,  32'd0);
        #10 rst_n = 1'b1;
        step();

        // Load-use: exactly one bubble.
        drive_lu(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        @(negedge clk); chk_all("lu_c0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        ex_valid = 1'b0; ex_L_type = 1'b0;
        @(negedge clk); chk_all("lu_c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Redirect with FLUSH_CYCLES=2.
        idle(); ex_redirect = 1'b1;
        @(negedge clk); chk_all("rd_c0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(); ex_redirect = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk); chk_all("rd_flush", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        @(negedge clk); chk_all("rd_c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("perf_stall_cycles", stall_cycles, exp_cnt(1));
        chk("perf_flush_count",  flush_count,  exp_cnt(1));
        step();

        // Load-use operand variants, each followed by an idle cycle.
        for (int v = 0; v < 6; v++) begin
            drive_lu(vecs[v].ev, vecs[v].lt, vecs[v].rd, vecs[v].iv,
                     vecs[v].r1, vecs[v].u1, vecs[v].r2, vecs[v].u2);
            @(negedge clk);
            chk($sformatf("luvec%0d_if_id_ready_go", v), if_id_ready_go, !vecs[v].stall);
            chk($sformatf("luvec%0d_id_ex_ready_go", v), id_ex_ready_go, !vecs[v].stall);
            step(); idle(); step();
        end

        // Memory wait of 3 cycles, redirect ignored while waiting.
        idle(); mem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ex_redirect = (k > 0);
            @(negedge clk); chk_all("mw_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        ex_redirect = 1'b0; dmem_ready = 1'b1;
        @(negedge clk); chk_all("mw_ack", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); idle();
        @(negedge clk); chk_all("mw_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // Redirect together with a load-use match: stall dropped.
        drive_lu(1'b1, 1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
        ex_redirect = 1'b1;
        @(negedge clk); chk_all("rd_lu", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(); idle();
        for (int k = 0; k < 3; k++) step();

        // Memory stall together with a redirect: stall wins.
        mem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
        @(negedge clk); chk_all("mw_rd", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); dmem_ready = 1'b1; ex_redirect = 1'b0;
        step(); idle(); step();

        // Redirect again inside FLUSH reloads the counter.
        ex_redirect = 1'b1; step();
        @(negedge clk); chk_all("rr_c1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(); ex_redirect = 1'b0;
        @(negedge clk); chk("rr_c2_if_id_clear", if_id_clear, 1'b1);
        step();
        @(negedge clk); chk("rr_c3_if_id_clear", if_id_clear, 1'b1);
        step();
        @(negedge clk); chk("rr_c4_if_id_clear", if_id_clear, 1'b0);
        step();

        // Memory stall inside FLUSH, flush resumes after the ack.
        ex_redirect = 1'b1; step(); ex_redirect = 1'b0;
        mem_req = 1'b1; dmem_ready = 1'b0;
        @(negedge clk); chk_all("fm_stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); dmem_ready = 1'b1;
        step(); idle();
        @(negedge clk); chk("fm_resume_if_id_clear", if_id_clear, 1'b1);
        for (int k = 0; k < 3; k++) step();

        // Asynchronous reset while in FLUSH.
        ex_redirect = 1'b1; step(); ex_redirect = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_all("arst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("arst_stall_cycles", stall_cycles, 32'd0);
        chk("arst_flush_count",  flush_count,  32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        @(negedge clk); chk_all("arst_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
